// File: rtl/sample_ram_controller_pkg.sv
// ----------------------------------------------------------------------------
// sample_ram_controller_pkg
//   Shared definitions for the circular sample store:
//   - readout FSM state encodings
//   - frame handshake constants
//   - default sample width and RAM address width
// ----------------------------------------------------------------------------
package sample_ram_controller_pkg;

  localparam int BITS_ADC_DEF   = 8;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int NUM_SAMPLES_W  = 16;

  // data_eof is raised on the word fetched while this many words remain.
  localparam int FRAME_LAST_COUNT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

endpackage

// File: rtl/sample_ram_controller_sdp_ram.sv
// ----------------------------------------------------------------------------
// sdp_ram
//   Simple dual-port RAM: one write port, one read port with a registered
//   output (one clock of read latency). No reset on the array or the read
//   register so that it maps onto block RAM.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read data
// ----------------------------------------------------------------------------
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/sample_ram_controller.sv
// ----------------------------------------------------------------------------
// sample_ram_controller
//   Circular sample store. While write_enable is high every input_rdy sample
//   is written at a free-running write pointer. After capture, a rqst_data
//   pulse streams the newest min(num_samples, fill) samples, oldest first,
//   over a rdy/ack/eof handshake with at most one word outstanding.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   input_sample    ADC sample, valid with input_rdy
//   input_rdy       one-cycle sample strobe
//   write_enable    1 while capture is running
//   num_samples     requested readout length
//   rqst_data       one-cycle readout request
//   data_out        frame word
//   data_rdy        data_out valid, held until data_ack
//   data_eof        last word of the frame (valid with data_rdy)
//   data_ack        consumer has taken data_out
//   busy            readout in progress
//   overrun         sticky: a sample was dropped during readout
// ----------------------------------------------------------------------------
module sample_ram_controller
  import sample_ram_controller_pkg::*;
#(
  parameter int BITS_ADC   = BITS_ADC_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_ADC-1:0]      input_sample,
  input  logic                     input_rdy,
  input  logic                     write_enable,
  input  logic [NUM_SAMPLES_W-1:0] num_samples,
  input  logic                     rqst_data,
  output logic [BITS_ADC-1:0]      data_out,
  output logic                     data_rdy,
  output logic                     data_eof,
  input  logic                     data_ack,
  output logic                     busy,
  output logic                     overrun
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Lengths and fill level need one extra bit to represent DEPTH itself.
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(FRAME_LAST_COUNT);

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
  logic [ADDR_WIDTH-1:0]   rd_ptr_reg;
  logic [LEN_W-1:0]        fill_reg;
  logic [LEN_W-1:0]        remaining_reg;
  logic [BITS_ADC-1:0]     data_out_reg;
  logic                    data_rdy_reg;
  logic                    data_eof_reg;
  logic                    busy_reg;
  logic                    overrun_reg;

  logic [BITS_ADC-1:0]     ram_rd_data;
  logic                    wr_fire;
  logic                    wr_drop;
  logic                    num_lt_fill;
  logic [LEN_W-1:0]        n_eff;
  logic                    rqst_ok;

  // Writes are frozen during readout so the frame being streamed cannot be
  // overwritten; a sample arriving then is lost and flagged instead.
  assign wr_fire = write_enable & input_rdy & ~busy_reg;
  assign wr_drop = write_enable & input_rdy &  busy_reg;

  // Compare at full request width so a large num_samples saturates to fill.
  assign num_lt_fill = ({1'b0, num_samples} <
                        {{(NUM_SAMPLES_W + 1 - LEN_W){1'b0}}, fill_reg});
  assign n_eff       = num_lt_fill ? num_samples[LEN_W-1:0] : fill_reg;

  // write_enable=0 is required, so a request coinciding with capture start
  // is rejected while the write proceeds.
  assign rqst_ok = rqst_data & (state_reg == ST_IDLE) & ~write_enable &
                   (n_eff != '0);

  sdp_ram #(
    .DATA_W (BITS_ADC),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_reg),
    .wr_data (input_sample),
    .rd_en   (state_reg == ST_ADDR),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fill_reg      <= '0;
      remaining_reg <= '0;
      data_out_reg  <= '0;
      data_rdy_reg  <= 1'b0;
      data_eof_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (fill_reg != FILL_MAX) begin
          fill_reg <= fill_reg + 1'b1;
        end
      end
      if (wr_drop) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (rqst_ok) begin
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            remaining_reg <= n_eff;
            // Mod-DEPTH subtraction; n_eff==DEPTH lands back on wr_ptr.
            rd_ptr_reg    <= wr_ptr_reg - n_eff[ADDR_WIDTH-1:0];
            state_reg     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          data_out_reg <= ram_rd_data;
          data_rdy_reg <= 1'b1;
          data_eof_reg <= (remaining_reg == LAST_CNT);
          state_reg    <= ST_SEND;
        end
        ST_SEND: begin
          if (data_ack) begin
            data_rdy_reg  <= 1'b0;
            data_eof_reg  <= 1'b0;
            rd_ptr_reg    <= rd_ptr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == LAST_CNT) begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_ADDR;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data_out = data_out_reg;
  assign data_rdy = data_rdy_reg;
  assign data_eof = data_eof_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;

endmodule
